// File: rtl/cdma_pkg.sv
// Shared constants, symbol payload type and output saturation for the CDMA transmit path.
package cdma_pkg;

  localparam int unsigned CHIPS_PER_BIT = 64;
  localparam int unsigned SAMPLE_W      = 8;
  localparam int unsigned SUM_W         = SAMPLE_W + 1;
  localparam int unsigned PN_W          = 6;
  localparam int          SAT_MAX       = 127;
  localparam int          SAT_MIN       = -128;

  // One user's data bit for the symbol currently on air, plus whether it carries data.
  typedef struct packed {
    logic bit_val;
    logic act;
  } sym_t;

  // Clamp the two-user sum into the signed sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [SUM_W-1:0] s);
    if (s > SUM_W'(SAT_MAX)) return SAMPLE_W'(SAT_MAX);
    if (s < SUM_W'(SAT_MIN)) return SAMPLE_W'(SAT_MIN);
    return SAMPLE_W'(s);
  endfunction

endpackage

// File: rtl/lfsr_6bit.sv
// 6-bit maximal-length PN generator (x^6 + x^5 + 1), shared with the receiver; advances every chip.
module lfsr_6bit
  import cdma_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic [PN_W-1:0] o_pn
);

  localparam logic [PN_W-1:0] SEED = PN_W'(1);

  logic [PN_W-1:0] r_state;

  // Shift left, feed back the XOR of the two top taps.
  always_ff @(posedge clk) begin
    if (rst) r_state <= SEED;
    else     r_state <= {r_state[PN_W-2:0], r_state[PN_W-1] ^ r_state[PN_W-2]};
  end

  assign o_pn = r_state;

endmodule

// File: rtl/tx_bit_fifo.sv
// Single-bit FIFO buffering one user's data bits until the next symbol boundary.
module tx_bit_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout_c,
  output logic o_full_c,
  output logic o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full_c;
  assign w_pop  = i_pop && !o_empty_c;

  // Pointer and occupancy tracking; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: it is only read when the count says it holds data.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout_c  = r_mem[r_rd_ptr];
  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/cdma_transmitter.sv
// Two-user DSSS transmitter: buffers bits, spreads each over a symbol of PN chips, sums and saturates.
module cdma_transmitter #(
  parameter int unsigned                          CHIPS_PER_BIT = cdma_pkg::CHIPS_PER_BIT,
  parameter int unsigned                          FIFO_DEPTH    = 4,
  parameter logic signed [cdma_pkg::SAMPLE_W-1:0] AMPLITUDE     = 8'sd40
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 data_in_1,
  input  logic                                 valid_in_1,
  output logic                                 ready_out_1,
  input  logic                                 data_in_2,
  input  logic                                 valid_in_2,
  output logic                                 ready_out_2,
  input  logic        [cdma_pkg::PN_W-1:0]     user_code_1,
  input  logic        [cdma_pkg::PN_W-1:0]     user_code_2,
  output logic signed [cdma_pkg::SAMPLE_W-1:0] bpsk_out,
  output logic                                 sym_start,
  output logic                                 active_1,
  output logic                                 active_2
);

  import cdma_pkg::*;

  localparam int unsigned CIDX_W = $clog2(CHIPS_PER_BIT);

  logic [CIDX_W-1:0]          r_chip_idx;
  logic                       w_load;
  logic [PN_W-1:0]            w_pn;
  logic                       w_full_1, w_empty_1, w_head_1;
  logic                       w_full_2, w_empty_2, w_head_2;
  sym_t                       r_sym_1, r_sym_2;
  logic                       w_chip_1, w_chip_2;
  logic signed [SUM_W-1:0]    w_s1, w_s2, w_sum;
  logic signed [SAMPLE_W-1:0] w_sat;

  // The last chip of a symbol is where the next symbol's bits are taken from the FIFOs.
  assign w_load      = (r_chip_idx == CIDX_W'(CHIPS_PER_BIT - 1));
  assign ready_out_1 = !w_full_1;
  assign ready_out_2 = !w_full_2;

  tx_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk      (clk),
    .rst      (rst),
    .i_push   (valid_in_1 && ready_out_1),
    .i_din    (data_in_1),
    .i_pop    (w_load),
    .o_dout_c (w_head_1),
    .o_full_c (w_full_1),
    .o_empty_c(w_empty_1)
  );

  tx_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_2 (
    .clk      (clk),
    .rst      (rst),
    .i_push   (valid_in_2 && ready_out_2),
    .i_din    (data_in_2),
    .i_pop    (w_load),
    .o_dout_c (w_head_2),
    .o_full_c (w_full_2),
    .o_empty_c(w_empty_2)
  );

  lfsr_6bit u_lfsr (
    .clk (clk),
    .rst (rst),
    .o_pn(w_pn)
  );

  // Free-running chip counter; wraps naturally since CHIPS_PER_BIT is a power of two.
  always_ff @(posedge clk) begin
    if (rst) r_chip_idx <= '0;
    else     r_chip_idx <= r_chip_idx + CIDX_W'(1);
  end

  // Symbol load: an empty FIFO leaves that user silent for the whole next symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym_1 <= '0;
      r_sym_2 <= '0;
    end else if (w_load) begin
      r_sym_1.act     <= !w_empty_1;
      r_sym_1.bit_val <= w_head_1 && !w_empty_1;
      r_sym_2.act     <= !w_empty_2;
      r_sym_2.bit_val <= w_head_2 && !w_empty_2;
    end
  end

  assign w_chip_1 = ^(w_pn & user_code_1);
  assign w_chip_2 = ^(w_pn & user_code_2);

  // BPSK chip mapping: bit XNOR chip gives +AMPLITUDE, so bit 1 correlates positive at the receiver.
  always_comb begin
    w_s1 = '0;
    w_s2 = '0;
    if (r_sym_1.act) w_s1 = (r_sym_1.bit_val ~^ w_chip_1) ? SUM_W'(AMPLITUDE) : -SUM_W'(AMPLITUDE);
    if (r_sym_2.act) w_s2 = (r_sym_2.bit_val ~^ w_chip_2) ? SUM_W'(AMPLITUDE) : -SUM_W'(AMPLITUDE);
    w_sum = w_s1 + w_s2;
    w_sat = sat_sample(w_sum);
  end

  // Output stage: one cycle behind the chip counter, flags aligned with the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      bpsk_out  <= '0;
      sym_start <= 1'b0;
      active_1  <= 1'b0;
      active_2  <= 1'b0;
    end else begin
      bpsk_out  <= w_sat;
      sym_start <= (r_chip_idx == '0);
      active_1  <= r_sym_1.act;
      active_2  <= r_sym_2.act;
    end
  end

endmodule

// File: tb/tb_cdma_transmitter.sv
// Self-checking bench for cdma_transmitter: lockstep behavioural model plus scenario checks.
module tb_cdma_transmitter;

  localparam int CPB    = 64;
  localparam int DEPTH  = 4;
  localparam int AMP_LO = 40;
  localparam int AMP_HI = 100;

  logic              clk;
  logic              rst;
  logic              data_in_1, valid_in_1, data_in_2, valid_in_2;
  logic [5:0]        user_code_1, user_code_2;
  logic              ready_out_1, ready_out_2, sym_start, active_1, active_2;
  logic signed [7:0] bpsk_out;
  logic              ready_out_1_h, ready_out_2_h, sym_start_h, active_1_h, active_2_h;
  logic signed [7:0] bpsk_out_h;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  logic [5:0]        pn_tab [0:62];
  bit                q1[$];
  bit                q2[$];
  int                m_cyc;
  bit                m_bit1, m_act1, m_bit2, m_act2;
  logic [5:0]        m_last_pn;
  logic signed [7:0] exp_bpsk, exp_hi;
  logic              exp_ss, exp_a1, exp_a2, exp_r1, exp_r2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cdma_transmitter #(.CHIPS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .AMPLITUDE(8'sd40)) dut (
    .clk(clk), .rst(rst),
    .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_out_1(ready_out_1),
    .data_in_2(data_in_2), .valid_in_2(valid_in_2), .ready_out_2(ready_out_2),
    .user_code_1(user_code_1), .user_code_2(user_code_2),
    .bpsk_out(bpsk_out), .sym_start(sym_start), .active_1(active_1), .active_2(active_2)
  );

  cdma_transmitter #(.CHIPS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .AMPLITUDE(8'sd100)) dut_hi (
    .clk(clk), .rst(rst),
    .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_out_1(ready_out_1_h),
    .data_in_2(data_in_2), .valid_in_2(valid_in_2), .ready_out_2(ready_out_2_h),
    .user_code_1(user_code_1), .user_code_2(user_code_2),
    .bpsk_out(bpsk_out_h), .sym_start(sym_start_h), .active_1(active_1_h), .active_2(active_2_h)
  );

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int user_sample(input bit act, input bit b, input logic [5:0] pn,
                                     input logic [5:0] code, input int amp);
    int c;
    c = $countones(pn & code) % 2;
    if (!act) return 0;
    return (int'(b) == c) ? amp : -amp;
  endfunction

  function automatic int rx_sign(input logic [5:0] pn, input logic [5:0] code);
    return ($countones(pn & code) % 2 == 1) ? 1 : -1;
  endfunction

  function automatic logic [25:0] obs_v();
    return {bpsk_out, bpsk_out_h, sym_start, active_1, active_2, ready_out_1, ready_out_2,
            sym_start_h, active_1_h, active_2_h, ready_out_1_h, ready_out_2_h};
  endfunction

  function automatic logic [25:0] exp_v();
    return {exp_bpsk, exp_hi, exp_ss, exp_a1, exp_a2, exp_r1, exp_r2,
            exp_ss, exp_a1, exp_a2, exp_r1, exp_r2};
  endfunction

  // Reference model: symbol-level behaviour with queues, one update per clock edge.
  always @(posedge clk) begin
    logic [5:0] pn;
    int chip, s1l, s2l, s1h, s2h;
    bit acc1, acc2;
    if (rst) begin
      m_cyc = 0; q1.delete(); q2.delete();
      m_bit1 = 0; m_act1 = 0; m_bit2 = 0; m_act2 = 0;
      exp_bpsk = 0; exp_hi = 0; exp_ss = 0; exp_a1 = 0; exp_a2 = 0; m_last_pn = 0;
    end else begin
      pn   = pn_tab[m_cyc % 63];
      chip = m_cyc % CPB;
      s1l = user_sample(m_act1, m_bit1, pn, user_code_1, AMP_LO);
      s2l = user_sample(m_act2, m_bit2, pn, user_code_2, AMP_LO);
      s1h = user_sample(m_act1, m_bit1, pn, user_code_1, AMP_HI);
      s2h = user_sample(m_act2, m_bit2, pn, user_code_2, AMP_HI);
      exp_bpsk = 8'(sat(s1l + s2l));
      exp_hi   = 8'(sat(s1h + s2h));
      exp_ss = (chip == 0); exp_a1 = m_act1; exp_a2 = m_act2; m_last_pn = pn;
      acc1 = q1.size() < DEPTH;
      acc2 = q2.size() < DEPTH;
      if (chip == CPB - 1) begin
        if (q1.size() > 0) begin m_bit1 = q1.pop_front(); m_act1 = 1; end else m_act1 = 0;
        if (q2.size() > 0) begin m_bit2 = q2.pop_front(); m_act2 = 1; end else m_act2 = 0;
      end
      if (valid_in_1 && acc1) q1.push_back(data_in_1);
      if (valid_in_2 && acc2) q2.push_back(data_in_2);
      m_cyc++;
    end
    exp_r1 = q1.size() < DEPTH;
    exp_r2 = q2.size() < DEPTH;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; valid_in_1 = 0; valid_in_2 = 0; data_in_1 = 0; data_in_2 = 0;
    user_code_1 = 6'b101101; user_code_2 = 6'b010011;
    repeat (3) step();
    n_total++;
    if ({bpsk_out, bpsk_out_h, sym_start, active_1, active_2, ready_out_1, ready_out_2} !== {16'd0, 5'b00011})
      $display("FAIL reset_initial got %h want %h", {bpsk_out, sym_start, active_1, active_2, ready_out_1, ready_out_2}, {8'd0, 5'b00011});
    else n_pass++;
    rst = 0;
    valid_in_1 = 1; data_in_1 = 1; valid_in_2 = 1; data_in_2 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 1) begin valid_in_1 = 0; valid_in_2 = 0; end
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL reset_pre t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if ({bpsk_out, sym_start, active_1, active_2, ready_out_1, ready_out_2} !== {8'd0, 5'b00011})
        $display("FAIL reset_mid got %h want %h", {bpsk_out, sym_start, active_1, active_2, ready_out_1, ready_out_2}, {8'd0, 5'b00011});
      else n_pass++;
    end
    rst = 0;
    step();
    n_total++;
    if ({sym_start, bpsk_out} !== {1'b1, 8'd0})
      $display("FAIL reset_first_sym_start got %b/%0d want 1/0", sym_start, bpsk_out);
    else n_pass++;
    for (int i = 0; i < 140; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL reset_post t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
  endtask

  task automatic test_single_user();
    int acc;
    bit found;
    for (int i = 0; i < CPB && (m_cyc % CPB) != 10; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL single_align t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    user_code_1 = 6'b101101; user_code_2 = 6'($urandom);
    data_in_1 = 1; valid_in_1 = 1;
    step();
    valid_in_1 = 0;
    found = 0;
    for (int i = 0; i < 70 && !found; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL single_wait t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
      if (sym_start) found = 1;
    end
    n_total++;
    if (!found) $display("FAIL single_sym_start timeout got 0 want 1");
    else n_pass++;
    acc = 0;
    for (int i = 0; i < CPB; i++) begin
      acc += int'(bpsk_out) * rx_sign(m_last_pn, user_code_1);
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL single_sym t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    n_total++;
    if (acc != CPB * AMP_LO) $display("FAIL single_correlation got %0d want %0d", acc, CPB * AMP_LO);
    else n_pass++;
  endtask

  task automatic test_two_users();
    int acc;
    bit found, inset;
    for (int i = 0; i < CPB && (m_cyc % CPB) != 10; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL two_align t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    user_code_1 = 6'b101101; user_code_2 = 6'b010011;
    data_in_1 = 1; valid_in_1 = 1; data_in_2 = 0; valid_in_2 = 1;
    step();
    valid_in_1 = 0; valid_in_2 = 0;
    found = 0;
    for (int i = 0; i < 70 && !found; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL two_wait t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
      if (sym_start_h) found = 1;
    end
    n_total++;
    if (!found) $display("FAIL two_sym_start timeout got 0 want 1");
    else n_pass++;
    acc = 0;
    for (int i = 0; i < CPB; i++) begin
      inset = (bpsk_out_h == 0) || (bpsk_out_h == 127) || (bpsk_out_h == -128);
      n_total++;
      if (!inset) $display("FAIL two_range got %0d want one of 0/127/-128", bpsk_out_h);
      else n_pass++;
      acc += int'(bpsk_out_h) * rx_sign(m_last_pn, user_code_1);
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL two_sym t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    n_total++;
    if (acc <= 0) $display("FAIL two_user1_decision got %0d want >0", acc);
    else n_pass++;
  endtask

  task automatic test_fifo_full();
    int accepted;
    bit rose;
    for (int i = 0; i < CPB && (m_cyc % CPB) != 5; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL full_align t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    accepted = 0;
    valid_in_1 = 1;
    for (int i = 0; i < 10; i++) begin
      data_in_1 = 1'($urandom);
      if (ready_out_1) accepted++;
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL full_push t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    valid_in_1 = 0;
    n_total++;
    if (accepted != DEPTH) $display("FAIL full_accepted got %0d want %0d", accepted, DEPTH);
    else n_pass++;
    n_total++;
    if (ready_out_1 !== 1'b0) $display("FAIL full_ready got %b want 0", ready_out_1);
    else n_pass++;
    rose = 0;
    for (int i = 0; i < 70 && !rose; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL full_drain t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
      if (ready_out_1) rose = 1;
    end
    n_total++;
    if (!rose || (m_cyc % CPB) != 0)
      $display("FAIL full_ready_rise got rose=%0d chip=%0d want rose=1 chip=0", rose, m_cyc % CPB);
    else n_pass++;
  endtask

  task automatic test_underrun();
    for (int i = 0; i < CPB && (m_cyc % CPB) != 0; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL under_align t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    for (int i = 0; i < 2 * CPB; i++) begin
      valid_in_2 = 0;
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL under_sym t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
      n_total++;
      if (active_2 !== 1'b0 || active_2_h !== 1'b0) $display("FAIL under_active2 got %b want 0", active_2);
      else n_pass++;
    end
  endtask

  task automatic test_simul_push_pop();
    for (int i = 0; i < 600 && q1.size() != 0; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL simul_drain t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    for (int i = 0; i < CPB && (m_cyc % CPB) != 20; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL simul_align t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    valid_in_1 = 1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      data_in_1 = 1'($urandom);
      step();
    end
    valid_in_1 = 0;
    for (int i = 0; i < CPB && (m_cyc % CPB) != CPB - 1; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL simul_wait t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    valid_in_1 = 1; data_in_1 = 1'($urandom);
    step();
    valid_in_1 = 0;
    n_total++;
    if (ready_out_1 !== 1'b1) $display("FAIL simul_occupancy_kept got ready=%b want 1", ready_out_1);
    else n_pass++;
    valid_in_1 = 1; data_in_1 = 1'($urandom);
    step();
    valid_in_1 = 0;
    n_total++;
    if (ready_out_1 !== 1'b0) $display("FAIL simul_full_after got ready=%b want 0", ready_out_1);
    else n_pass++;
    for (int i = 0; i < 5 * CPB; i++) begin
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL simul_order t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * CPB; i++) begin
      valid_in_1 = ($urandom_range(0, 3) == 0);
      valid_in_2 = ($urandom_range(0, 3) == 0);
      data_in_1  = 1'($urandom);
      data_in_2  = 1'($urandom);
      if (i % 17 == 0) begin
        user_code_1 = 6'($urandom);
        user_code_2 = 6'($urandom);
      end
      step();
      n_total++;
      if (obs_v() !== exp_v()) $display("FAIL random t=%0t got %h want %h", $time, obs_v(), exp_v());
      else n_pass++;
    end
    valid_in_1 = 0; valid_in_2 = 0;
  endtask

  initial begin
    bit b [0:68];
    for (int j = 0; j < 6; j++) b[j] = 0;
    b[5] = 1;
    for (int j = 6; j < 69; j++) b[j] = b[j-6] ^ b[j-5];
    for (int n = 0; n < 63; n++)
      for (int k = 0; k < 6; k++) pn_tab[n][k] = b[n+5-k];

    rst = 1; valid_in_1 = 0; valid_in_2 = 0; data_in_1 = 0; data_in_2 = 0;
    user_code_1 = '0; user_code_2 = '0;
    exp_bpsk = 0; exp_hi = 0; exp_ss = 0; exp_a1 = 0; exp_a2 = 0; exp_r1 = 1; exp_r2 = 1;
    m_cyc = 0; m_last_pn = 0;

    test_reset();
    test_single_user();
    test_two_users();
    test_fifo_full();
    test_underrun();
    test_simul_push_pop();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
